// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, stop bit.
// Each bit is held for a latched prescale number of clock cycles.
module uart_tx #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       DATA_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] Prescale,
  output logic       TX_OUT,
  output logic       Busy
);

  localparam int unsigned CntW = $clog2(64);
  localparam logic [CntW-1:0] PeriodRst = (PRESCALE == 0) ? CntW'(1) : CntW'(PRESCALE);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] edge_cnt_q, edge_cnt_d;
  logic [CntW-1:0] period_q, period_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            bit_done;

  assign bit_done = (edge_cnt_q == period_q - CntW'(1));

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    period_d   = period_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    if (state_q != StIdle) begin
      edge_cnt_d = bit_done ? '0 : edge_cnt_q + CntW'(1);
    end

    // tx_d always carries the level of the bit that starts at the next edge.
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (DATA_Valid) begin
          state_d    = StStart;
          shift_d    = P_DATA;
          par_en_d   = PAR_EN;
          par_bit_d  = (^P_DATA) ^ PAR_TYP;
          period_d   = (Prescale == '0) ? CntW'(1) : Prescale;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = par_en_q ? StParity : StStop;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          state_d = StIdle;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      period_q   <= PeriodRst;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      period_q   <= period_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: fixed vectors, corner-case sequences, random frames
// against a frame-level model, and a behavioural serial receiver on TX_OUT.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic       lb_en = 1'b0;
  logic       lb_pe = 1'b0;
  logic       lb_pt = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;

  uart_tx #(.PRESCALE(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_Valid (DATA_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [7:0]  d;
    logic        pe;
    logic        pt;
    logic [5:0]  ps;
    logic [10:0] bits;
    int          n;
  } vec_t;

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic cmp32(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame as a bit list, index 0 = start bit.
  function automatic logic [10:0] model_bits(input logic [7:0] d, input logic pe, input logic pt);
    logic [10:0] f;
    logic        par;
    f   = '0;
    par = pt ^ (($countones(d) % 2) == 1);
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = pe ? par : 1'b1;
    f[10] = pe;
    return f;
  endfunction

  function automatic int eff_p(input logic [5:0] ps);
    return (ps == 6'd0) ? 1 : int'(ps);
  endfunction

  task automatic accept(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    DATA_Valid = 1'b1;
    @(posedge CLK);
    #1;
    DATA_Valid = 1'b0;
  endtask

  // Entered #1 after the accept edge; returns #1 into the idle cycle after the frame.
  task automatic check_frame(input string name, input logic [10:0] exp, input int n, input int p,
                             input bit disturb);
    for (int c = 1; c <= n * p; c++) begin
      if (disturb && c == 3 * p) begin
        DATA_Valid = 1'b1;
        P_DATA     = 8'h12;
        PAR_TYP    = ~PAR_TYP;
        Prescale   = Prescale + 6'd3;
      end
      if (disturb && c == 3 * p + 1) DATA_Valid = 1'b0;
      cmp1($sformatf("%s tx c%0d", name, c), TX_OUT, exp[(c-1)/p]);
      cmp1($sformatf("%s busy c%0d", name, c), Busy, 1'b1);
      @(posedge CLK);
      #1;
    end
    cmp1($sformatf("%s idle tx", name), TX_OUT, 1'b1);
    cmp1($sformatf("%s idle busy", name), Busy, 1'b0);
  endtask

  // Behavioural receiver sampling mid-bit at P=16.
  initial begin
    forever begin
      @(negedge TX_OUT);
      if (lb_en) begin
        repeat (8) @(posedge CLK);
        #1;
        cmp1("lb start", TX_OUT, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge CLK);
          #1;
          rx_b[i] = TX_OUT;
        end
        if (lb_pe) begin
          repeat (16) @(posedge CLK);
          #1;
          cmp1("lb parity", TX_OUT, lb_pt ^ (($countones(rx_b) % 2) == 1));
        end
        repeat (16) @(posedge CLK);
        #1;
        cmp1("lb stop", TX_OUT, 1'b1);
        rx_q.push_back(rx_b);
      end
    end
  end

  initial begin
    vec_t vecs[4];
    logic [7:0] lb_data[3];
    logic       lb_pes[3];
    logic       lb_pts[3];

    vecs[0] = '{"odd a5",  8'hA5, 1'b1, 1'b1, 6'd16, 11'b11101001010, 11};
    vecs[1] = '{"even 3c", 8'h3C, 1'b1, 1'b0, 6'd8,  11'b10001111000, 11};
    vecs[2] = '{"ps0 96",  8'h96, 1'b0, 1'b0, 6'd0,  11'b01100101100, 10};
    vecs[3] = '{"ps1 01",  8'h01, 1'b1, 1'b1, 6'd1,  11'b10000000010, 11};

    RST        = 1'b1;
    P_DATA     = '0;
    DATA_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd16;
    #1;
    cmp1("reset tx", TX_OUT, 1'b1);
    cmp1("reset busy", Busy, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    cmp1("post-reset tx", TX_OUT, 1'b1);
    cmp1("post-reset busy", Busy, 1'b0);

    foreach (vecs[i]) begin
      accept(vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].ps);
      check_frame(vecs[i].name, vecs[i].bits, vecs[i].n, eff_p(vecs[i].ps), 1'b0);
    end

    // Back-to-back with DATA_Valid held high; second frame samples its own P_DATA.
    @(negedge CLK);
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd16;
    DATA_Valid = 1'b1;
    @(posedge CLK);
    #1;
    P_DATA = 8'h00;
    check_frame("b2b ff", model_bits(8'hFF, 1'b0, 1'b0), 10, 16, 1'b0);
    @(posedge CLK);
    #1;
    check_frame("b2b 00", model_bits(8'h00, 1'b0, 1'b0), 10, 16, 1'b0);
    DATA_Valid = 1'b0;

    // Request and config changes during a frame must be ignored.
    accept(8'h81, 1'b1, 1'b0, 6'd8);
    check_frame("ignore 81", model_bits(8'h81, 1'b1, 1'b0), 11, 8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      cmp1($sformatf("no 12 busy %0d", k), Busy, 1'b0);
      cmp1($sformatf("no 12 tx %0d", k), TX_OUT, 1'b1);
    end

    // Reset during frame bit 4 (a 0 bit of 0xC7).
    accept(8'hC7, 1'b1, 1'b0, 6'd16);
    repeat (69) @(posedge CLK);
    #1;
    cmp1("pre-reset tx", TX_OUT, 1'b0);
    RST = 1'b1;
    #1;
    cmp1("mid reset tx", TX_OUT, 1'b1);
    cmp1("mid reset busy", Busy, 1'b0);
    @(posedge CLK);
    #1;
    cmp1("held reset busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    accept(8'h5A, 1'b1, 1'b0, 6'd16);
    check_frame("after reset 5a", model_bits(8'h5A, 1'b1, 1'b0), 11, 16, 1'b0);

    // Random frames against the model.
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic [5:0] ps;
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = 6'($urandom_range(0, 10));
      accept(d, pe, pt, ps);
      check_frame($sformatf("rand%0d %02h", r, d), model_bits(d, pe, pt), pe ? 11 : 10, eff_p(ps),
                  1'b0);
    end

    // Loopback through the behavioural receiver.
    lb_data = '{8'hA5, 8'h3C, 8'hC3};
    lb_pes  = '{1'b1, 1'b1, 1'b0};
    lb_pts  = '{1'b1, 1'b0, 1'b0};
    rx_q.delete();
    lb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      lb_pe = lb_pes[i];
      lb_pt = lb_pts[i];
      accept(lb_data[i], lb_pes[i], lb_pts[i], 6'd16);
      check_frame($sformatf("lb%0d", i), model_bits(lb_data[i], lb_pes[i], lb_pts[i]),
                  lb_pes[i] ? 11 : 10, 16, 1'b0);
    end
    lb_en = 1'b0;
    cmp32("lb count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_q.size()) cmp32($sformatf("lb byte%0d", i), int'(rx_q[i]), int'(lb_data[i]));
      else cmp32($sformatf("lb byte%0d missing", i), -1, int'(lb_data[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
